// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam int MEM_TIMEOUT_DEF = 16;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when a source operand is actually read and names the given register.
  function automatic logic src_match(input logic use_src, input logic [4:0] rs,
                                     input logic [4:0] rd);
    return use_src && (rs == rd);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: step by one unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze with timeout, branch
// flush and load-use stall, in priority order freeze > flush > stall.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             busy,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt,
`endif
  output logic             mem_err
);

  if ((MEM_TIMEOUT < 2) || (MEM_TIMEOUT > 255) || (CNT_W < 1)) begin : g_param_chk
    $error("pipe_hazard_ctrl: MEM_TIMEOUT must be 2..255 and CNT_W >= 1");
  end

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;

  logic load_use;
  logic frozen;
  logic timeout;
  logic stall_ev;
  logic flush_ev;
  logic freeze_ev;

  assign load_use = id_ex_memread && (id_ex_rd != REG_ZERO) &&
                    (src_match(id_use_rs1, id_rs1, id_ex_rd) ||
                     src_match(id_use_rs2, id_rs2, id_ex_rd));

  // Next state, wait counter and freeze/timeout detection.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    frozen  = 1'b0;
    timeout = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          frozen  = 1'b1;
          state_d = MEM_WAIT;
          wcnt_d  = 8'd0;
        end
      end
      MEM_WAIT: begin
        wcnt_d = wcnt_q + 8'd1;
        if (mem_ready) begin
          state_d = RUN;
        end else if (wcnt_q == TMO_LAST) begin
          // Give up on the access: release the pipe and report it once.
          timeout = 1'b1;
          state_d = RUN;
        end else begin
          frozen = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Stage enables and flushes by priority; reset forces all-hold, all-bubble.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    busy         = (state_q == MEM_WAIT);
    mem_err      = timeout;
    stall_ev     = 1'b0;
    flush_ev     = 1'b0;
    freeze_ev    = 1'b0;
    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
      busy         = 1'b0;
      mem_err      = 1'b0;
    end else if (frozen) begin
      // The whole pipe holds; only the write-back slot drains as a bubble.
      freeze_ev    = 1'b1;
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      flush_ev    = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      // Hold fetch/decode one cycle and let the load move on out of EX.
      stall_ev    = 1'b1;
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  sat_counter #(.W(CNT_W)) u_lu_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_ev),
    .cnt (lu_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_ev),
    .cnt (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_memwait_cnt (
    .clk (clk),
    .rst (rst),
    .inc (freeze_ev),
    .cnt (memwait_cnt)
  );
`else
  logic unused_ev;
  assign unused_ev = stall_ev ^ flush_ev ^ freeze_ev;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a cycle-class reference model.
module tb_pipe_hazard_ctrl;

  localparam int TMO   = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_ex_rd = '0;
  logic       id_use_rs1 = 0, id_use_rs2 = 0, id_ex_memread = 0;
  logic       ex_branch_taken = 0, mem_req = 0, mem_ready = 0;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic       if_id_flush, id_ex_flush, mem_wb_flush, busy, mem_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] lu_stall_cnt, flush_cnt, memwait_cnt;
`endif

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
    .busy(busy),
`ifdef HAZARD_PERF_CNT_EN
    .lu_stall_cnt(lu_stall_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt),
`endif
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a memory access is outstanding for a number of wait
  // cycles; every cycle falls into one class which fixes all outputs.
  bit waiting = 0;
  int wait_n  = 0;
  int m_lu = 0, m_fl = 0, m_fz = 0;
  int cls;            // 0 reset, 1 frozen, 2 branch, 3 stall, 4 normal
  bit m_tmo;
  logic [8:0] got_v;

  function automatic logic [8:0] class_vec(input int c, input bit bsy, input bit err);
    logic [6:0] v;
    case (c)
      0:       v = 7'b0000_111;
      1:       v = 7'b0000_001;
      2:       v = 7'b1111_110;
      3:       v = 7'b0011_010;
      default: v = 7'b1111_000;
    endcase
    return {v, bsy, err};
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Classify the current cycle from model state and present inputs.
  task automatic classify();
    bit hz, frz;
    hz = id_ex_memread && (id_ex_rd != 0) &&
         ((id_use_rs1 && id_rs1 == id_ex_rd) || (id_use_rs2 && id_rs2 == id_ex_rd));
    m_tmo = 0;
    if (rst) begin
      waiting = 0; wait_n = 0; m_lu = 0; m_fl = 0; m_fz = 0;
      cls = 0;
      return;
    end
    if (waiting) begin
      m_tmo = !mem_ready && (wait_n == TMO - 1);
      frz   = !mem_ready && !m_tmo;
    end else begin
      frz = mem_req && !mem_ready;
    end
    if (frz)                  cls = 1;
    else if (ex_branch_taken) cls = 2;
    else if (hz)              cls = 3;
    else                      cls = 4;
  endtask

  task automatic compare(input string tag);
    got_v = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
             mem_wb_flush, busy, mem_err};
    chk(tag, 64'(got_v), 64'(class_vec(cls, waiting && !rst, m_tmo)));
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, "_lucnt"}, 64'(lu_stall_cnt), 64'(m_lu));
    chk({tag, "_flcnt"}, 64'(flush_cnt), 64'(m_fl));
    chk({tag, "_mwcnt"}, 64'(memwait_cnt), 64'(m_fz));
`endif
  endtask

  // Advance model state across a clock edge using the held inputs.
  task automatic advance();
    if (rst) return;
    if (cls == 1) m_fz = sat_inc(m_fz);
    if (cls == 2) m_fl = sat_inc(m_fl);
    if (cls == 3) m_lu = sat_inc(m_lu);
    if (waiting) begin
      if (mem_ready || m_tmo) waiting = 0;
      else wait_n++;
    end else if (mem_req && !mem_ready) begin
      waiting = 1;
      wait_n  = 0;
    end
  endtask

  // Inputs are applied at the falling edge, checked 1 ns later, then clocked.
  task automatic cyc(input string tag);
    #1;
    classify();
    compare(tag);
    @(posedge clk);
    advance();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    id_rs1 = 0; id_rs2 = 0; id_ex_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_ex_memread = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  int err_at;
  int frz_n;

  initial begin
    rst = 1;
    idle_inputs();
    @(negedge clk);
    cyc("reset");
    cyc("reset2");
    rst = 0;
    cyc("first_run");
    chk("first_run_pc_en", 64'(pc_en), 64'd1);

    // Load-use stall and its rd = 0 exception.
    id_ex_memread = 1; id_ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    #1;
    chk("lu_pc_en", 64'(pc_en), 64'd0);
    chk("lu_idex_flush", 64'(id_ex_flush), 64'd1);
    cyc("lu");
    id_ex_rd = 0; id_rs1 = 0;
    #1;
    chk("lu_rd0_pc_en", 64'(pc_en), 64'd1);
    cyc("lu_rd0");

    // Branch overrides load-use.
    id_ex_rd = 5; id_rs1 = 5; ex_branch_taken = 1;
    #1;
    chk("br_lu_ifid_flush", 64'(if_id_flush), 64'd1);
    chk("br_lu_pc_en", 64'(pc_en), 64'd1);
    cyc("br_lu");
    idle_inputs();

    // Three frozen cycles, released when ready arrives on the fourth.
    frz_n = 0;
    mem_req = 1;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      if (pc_en == 0 && mem_wb_flush == 1) frz_n++;
      if (i == 3) chk("wait_release_pc_en", 64'(pc_en), 64'd1);
      cyc("wait3");
    end
    chk("wait3_frozen_cycles", 64'(frz_n), 64'd3);
    idle_inputs();
    cyc("after_wait");

    // Timeout: ready never comes.
    err_at = -1;
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (mem_err && err_at < 0) err_at = i;
      cyc("timeout");
    end
    chk("timeout_cycle", 64'(err_at), 64'd4);
    idle_inputs();
    cyc("after_timeout");
    chk("after_timeout_busy", 64'(busy), 64'd0);

    // Branch during freeze, flushed on release.
    mem_req = 1; ex_branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 2);
      #1;
      if (i < 2) chk("br_frz_noflush", 64'(if_id_flush), 64'd0);
      else       chk("br_rel_flush", 64'({if_id_flush, id_ex_flush}), 64'd3);
      cyc("br_frz");
    end
    idle_inputs();

    // Reset mid-wait aborts without an error pulse.
    mem_req = 1;
    cyc("pre_rst_wait");
    cyc("pre_rst_wait2");
    #2 rst = 1;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_err", 64'(mem_err), 64'd0);
    @(negedge clk);
    cyc("rst_mid");
    rst = 0;
    cyc("post_rst");

    // Randomized traffic with bursts of slow memory.
    for (int i = 0; i < 3000; i++) begin
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      id_ex_rd = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom_range(0, 1));
      id_use_rs2 = 1'($urandom_range(0, 1));
      id_ex_memread = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      mem_req = ($urandom_range(0, 3) == 0);
      mem_ready = (i % 400 < 200) ? ($urandom_range(0, 1) == 1)
                                  : ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 499) == 0);
      cyc("rand");
    end
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
